// File: rtl/plic_v2_if.sv
// Register port of plic_v2: one write channel (wen/waddr/wdata/wstrb) and one read
// channel (ren/raddr) with combinational read data.
interface plic_v2_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wen;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [31:0]       rdata;

  modport master (output waddr, wdata, wstrb, wen, raddr, ren, input rdata);
  modport slave  (input waddr, wdata, wstrb, wen, raddr, ren, output rdata);
endinterface

// File: rtl/plic_v2.sv
// Platform interrupt controller: per-source level/edge gateway, priority arbiter with threshold,
// claim/complete over a simple register port. Define PLIC_V2_VECTOR_EN for per-source vectors and mvec.
module plic_v2 #(
  parameter  int NUM_SRC = 8,
  parameter  int PRI_W   = 3,
  parameter  int ADDR_W  = 12,
  localparam int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  plic_v2_if.slave           bus,
  input  logic [NUM_SRC-1:0] irq_sources,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id
`ifdef PLIC_V2_VECTOR_EN
  ,
  output logic [31:0]        mvec
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  localparam logic [ADDR_W-1:0] A_EN     = ADDR_W'(32'h000);
  localparam logic [ADDR_W-1:0] A_TRIG   = ADDR_W'(32'h004);
  localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(32'h008);
  localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(32'h00C);
  localparam logic [ADDR_W-1:0] A_CLAIM  = ADDR_W'(32'h010);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] mask);
    return (old & ~mask) | (wd & mask);
  endfunction

  logic [NUM_SRC-1:0]       en_reg, trig_reg, trig_next, line_q_reg;
  logic [PRI_W-1:0]         thresh_reg;
  logic [NUM_SRC*PRI_W-1:0] pri_flat;
  logic [NUM_SRC-1:0]       pend, cand, claim_vec;
  logic                     irq_valid_reg;
  logic [ID_W-1:0]          irq_id_reg;
  logic [31:0]              wmask, rd_data;
  logic                     wr_en, wr_trig, wr_thresh, wr_claim, claim_rd, claim_ok;
  logic                     best_found;
  logic [PRI_W-1:0]         best_pri;
  logic [ID_W-1:0]          best_id;

  assign wmask     = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign wr_en     = bus.wen && (bus.waddr == A_EN);
  assign wr_trig   = bus.wen && (bus.waddr == A_TRIG);
  assign wr_thresh = bus.wen && (bus.waddr == A_THRESH);
  assign wr_claim  = bus.wen && (bus.waddr == A_CLAIM);
  assign claim_rd  = bus.ren && (bus.raddr == A_CLAIM);
  assign claim_ok  = |claim_vec;
  assign trig_next = wr_trig ? NUM_SRC'(merge(32'(trig_reg), bus.wdata, wmask)) : trig_reg;

`ifdef PLIC_V2_VECTOR_EN
  localparam logic [ADDR_W-1:0] A_MVEC = ADDR_W'(32'h014);
  logic [NUM_SRC*32-1:0] vec_flat;
  logic [31:0]           mvec_reg, mvec_next;
  assign mvec = mvec_reg;
`endif

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    localparam logic [ADDR_W-1:0] A_PRI = ADDR_W'(32'h100 + 4 * gi);
    logic [PRI_W-1:0] pri_reg;
    logic [1:0]       st_reg, st_next;
    logic             latch_reg, latch_next;
    logic             edge_det, req, complete_me;

    assign edge_det     = irq_sources[gi] & ~line_q_reg[gi];
    assign req          = trig_reg[gi] ? edge_det : irq_sources[gi];
    assign complete_me  = wr_claim && (bus.wdata[ID_W-1:0] == ID_W'(gi + 1));
    assign pend[gi]     = (st_reg == S_PEND);
    assign cand[gi]     = pend[gi] && en_reg[gi] && (pri_reg > thresh_reg);
    // A claim only succeeds if the registered winner is still a candidate right now.
    assign claim_vec[gi] = claim_rd && (irq_id_reg == ID_W'(gi + 1)) && cand[gi];
    assign pri_flat[gi*PRI_W +: PRI_W] = pri_reg;

    always_comb begin
      st_next    = st_reg;
      latch_next = latch_reg;
      case (st_reg)
        S_IDLE: if (req) st_next = S_PEND;
        S_PEND: begin
          if (trig_reg[gi] && edge_det) latch_next = 1'b1;
          if (claim_vec[gi]) st_next = S_SERV;
        end
        S_SERV: begin
          if (complete_me) begin
            latch_next = 1'b0;
            st_next    = (latch_reg || req) ? S_PEND : S_IDLE;
          end else if (trig_reg[gi] && edge_det) begin
            latch_next = 1'b1;
          end
        end
        default: st_next = S_IDLE;
      endcase
      if (trig_next[gi] != trig_reg[gi]) latch_next = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_reg    <= S_IDLE;
        latch_reg <= 1'b0;
        pri_reg   <= '0;
      end else begin
        st_reg    <= st_next;
        latch_reg <= latch_next;
        if (bus.wen && bus.waddr == A_PRI)
          pri_reg <= PRI_W'(merge(32'(pri_reg), bus.wdata, wmask));
      end
    end

`ifdef PLIC_V2_VECTOR_EN
    localparam logic [ADDR_W-1:0] A_VEC = ADDR_W'(32'h200 + 4 * gi);
    logic [31:0] vec_reg;
    assign vec_flat[gi*32 +: 32] = vec_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) vec_reg <= '0;
      else if (bus.wen && bus.waddr == A_VEC) vec_reg <= merge(vec_reg, bus.wdata, wmask);
    end
`endif
  end

  // Highest priority wins; strict compare keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_pri   = '0;
    best_id    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cand[k] && (!best_found || pri_flat[k*PRI_W +: PRI_W] > best_pri)) begin
        best_found = 1'b1;
        best_pri   = pri_flat[k*PRI_W +: PRI_W];
        best_id    = ID_W'(k + 1);
      end
    end
  end

`ifdef PLIC_V2_VECTOR_EN
  always_comb begin
    mvec_next = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (best_id == ID_W'(k + 1)) mvec_next = vec_flat[k*32 +: 32];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg        <= '0;
      trig_reg      <= '0;
      thresh_reg    <= '0;
      line_q_reg    <= '0;
      irq_valid_reg <= 1'b0;
      irq_id_reg    <= '0;
`ifdef PLIC_V2_VECTOR_EN
      mvec_reg      <= '0;
`endif
    end else begin
      if (wr_en) en_reg <= NUM_SRC'(merge(32'(en_reg), bus.wdata, wmask));
      if (wr_thresh) thresh_reg <= PRI_W'(merge(32'(thresh_reg), bus.wdata, wmask));
      trig_reg      <= trig_next;
      line_q_reg    <= irq_sources;
      irq_valid_reg <= best_found;
      irq_id_reg    <= best_id;
`ifdef PLIC_V2_VECTOR_EN
      mvec_reg      <= mvec_next;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.raddr == A_EN)          rd_data = 32'(en_reg);
    else if (bus.raddr == A_TRIG)   rd_data = 32'(trig_reg);
    else if (bus.raddr == A_PEND)   rd_data = 32'(pend);
    else if (bus.raddr == A_THRESH) rd_data = 32'(thresh_reg);
    else if (bus.raddr == A_CLAIM)  rd_data = (bus.ren && !claim_ok) ? 32'd0 : 32'(irq_id_reg);
`ifdef PLIC_V2_VECTOR_EN
    else if (bus.raddr == A_MVEC)   rd_data = mvec_reg;
    for (int k = 0; k < NUM_SRC; k++)
      if (bus.raddr == ADDR_W'(32'h200 + 4 * k)) rd_data = vec_flat[k*32 +: 32];
`endif
    for (int k = 0; k < NUM_SRC; k++)
      if (bus.raddr == ADDR_W'(32'h100 + 4 * k)) rd_data = 32'(pri_flat[k*PRI_W +: PRI_W]);
  end

  assign bus.rdata = rd_data;
  assign irq_valid = irq_valid_reg;
  assign irq_id    = irq_id_reg;
endmodule

// File: tb/tb_plic_v2.sv
// Directed and randomized bench for plic_v2 against a behavioural interrupt-controller model.
module tb_plic_v2;
  localparam int NUM_SRC = 8;
  localparam int PRI_W   = 3;
  localparam int ADDR_W  = 12;
  localparam int ID_W    = $clog2(NUM_SRC + 1);
  localparam int PRI_MAX = (1 << PRI_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] irq_sources = '0;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
`ifdef PLIC_V2_VECTOR_EN
  logic [31:0]        mvec;
`endif

  plic_v2_if #(.ADDR_W(ADDR_W)) bus ();

  plic_v2 #(.NUM_SRC(NUM_SRC), .PRI_W(PRI_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .irq_sources(irq_sources),
    .irq_valid(irq_valid), .irq_id(irq_id)
`ifdef PLIC_V2_VECTOR_EN
    , .mvec(mvec)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: gateway condition per source is 0 = idle, 1 = pending, 2 = in service.
  bit [NUM_SRC-1:0] m_en, m_trig, m_prev;
  int               m_thresh;
  int               m_pri [NUM_SRC];
  logic [31:0]      m_vec [NUM_SRC];
  int               m_gw [NUM_SRC];
  bit               m_extra [NUM_SRC];
  bit               m_valid;
  int               m_id;
  logic [31:0]      m_mvec;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_cand(int k);
    return m_gw[k] == 1 && m_en[k] && m_pri[k] > m_thresh;
  endfunction

  function automatic int model_best();
    int b = 0;
    int bp = -1;
    for (int k = 0; k < NUM_SRC; k++)
      if (is_cand(k) && m_pri[k] > bp) begin
        bp = m_pri[k];
        b  = k + 1;
      end
    return b;
  endfunction

  function automatic logic [31:0] m_read(int a, bit rd);
    logic [31:0] p = '0;
    if (a == 'h0) return 32'(m_en);
    if (a == 'h4) return 32'(m_trig);
    if (a == 'h8) begin
      for (int k = 0; k < NUM_SRC; k++) p[k] = (m_gw[k] == 1);
      return p;
    end
    if (a == 'hC) return 32'(m_thresh);
    if (a == 'h10) begin
      if (rd && !(m_id != 0 && is_cand(m_id - 1))) return 32'd0;
      return 32'(m_id);
    end
    if (a >= 'h100 && a < 'h100 + 4 * NUM_SRC && a % 4 == 0) return 32'(m_pri[(a - 'h100) / 4]);
`ifdef PLIC_V2_VECTOR_EN
    if (a == 'h14) return m_mvec;
    if (a >= 'h200 && a < 'h200 + 4 * NUM_SRC && a % 4 == 0) return m_vec[(a - 'h200) / 4];
`endif
    return 32'd0;
  endfunction

  // One clock: check read data, advance the model across the edge, check registered outputs.
  task automatic cycle();
    bit [NUM_SRC-1:0] line, ntrig;
    int          nb, comp, a, ng [NUM_SRC];
    bit          nx [NUM_SRC];
    bit          claim_ok, edge_k, req_k, we;
    logic [31:0] m, d;
    #2;
    check("rdata", bus.rdata, m_read(int'(bus.raddr), bus.ren));
    line     = irq_sources;
    nb       = model_best();
    claim_ok = bus.ren && bus.raddr == 12'h010 && m_id != 0 && is_cand(m_id - 1);
    we       = bus.wen;
    a        = int'(bus.waddr);
    d        = bus.wdata;
    comp     = (we && a == 'h10) ? int'(bus.wdata[ID_W-1:0]) : 0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = bus.wstrb[b] ? 8'hFF : 8'h00;
    ntrig = m_trig;
    if (we && a == 'h4) ntrig = NUM_SRC'((32'(m_trig) & ~m) | (d & m));
    for (int k = 0; k < NUM_SRC; k++) begin
      edge_k = line[k] && !m_prev[k];
      req_k  = m_trig[k] ? edge_k : line[k];
      ng[k]  = m_gw[k];
      nx[k]  = m_extra[k];
      if (m_gw[k] == 0 && req_k) ng[k] = 1;
      if (m_gw[k] == 1) begin
        if (m_trig[k] && edge_k) nx[k] = 1;
        if (claim_ok && m_id == k + 1) ng[k] = 2;
      end
      if (m_gw[k] == 2) begin
        if (comp == k + 1) begin
          ng[k] = (m_extra[k] || req_k) ? 1 : 0;
          nx[k] = 0;
        end else if (m_trig[k] && edge_k) nx[k] = 1;
      end
      if (ntrig[k] != m_trig[k]) nx[k] = 0;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_en = '0; m_trig = '0; m_prev = '0; m_thresh = 0;
      m_valid = 0; m_id = 0; m_mvec = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        m_pri[k] = 0; m_vec[k] = '0; m_gw[k] = 0; m_extra[k] = 0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        m_gw[k] = ng[k];
        m_extra[k] = nx[k];
      end
      m_prev = line;
      m_trig = ntrig;
      if (we && a == 'h0) m_en = NUM_SRC'((32'(m_en) & ~m) | (d & m));
      if (we && a == 'hC) m_thresh = int'(((32'(m_thresh) & ~m) | (d & m)) & PRI_MAX);
      if (we && a >= 'h100 && a < 'h100 + 4 * NUM_SRC && a % 4 == 0)
        m_pri[(a - 'h100) / 4] = int'(((32'(m_pri[(a - 'h100) / 4]) & ~m) | (d & m)) & PRI_MAX);
      if (we && a >= 'h200 && a < 'h200 + 4 * NUM_SRC && a % 4 == 0)
        m_vec[(a - 'h200) / 4] = (m_vec[(a - 'h200) / 4] & ~m) | (d & m);
      m_valid = (nb != 0);
      m_id    = nb;
      m_mvec  = (nb != 0) ? m_vec[nb - 1] : 32'd0;
    end
    #1;
    check("irq_valid", 32'(irq_valid), 32'(m_valid));
    check("irq_id", 32'(irq_id), 32'(m_id));
`ifdef PLIC_V2_VECTOR_EN
    check("mvec", mvec, m_mvec);
`endif
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] s = 4'hF);
    bus.waddr = ADDR_W'(a);
    bus.wdata = d;
    bus.wstrb = s;
    bus.wen   = 1'b1;
    cycle();
    bus.wen   = 1'b0;
  endtask

  task automatic claim(logic [31:0] exp, string tag);
    bus.raddr = 12'h010;
    bus.ren   = 1'b1;
    #1;
    check(tag, bus.rdata, exp);
    cycle();
    bus.ren   = 1'b0;
  endtask

  task automatic peek(int a, logic [31:0] exp, string tag);
    bus.raddr = ADDR_W'(a);
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 7))
      0: return 'h0;
      1: return 'h4;
      2: return 'h8;
      3: return 'hC;
      4: return 'h10;
      5: return 'h100 + 4 * $urandom_range(0, NUM_SRC);
      6: return ($urandom_range(0, 1) == 0) ? 'h14 : 'h200 + 4 * $urandom_range(0, NUM_SRC - 1);
      default: return ($urandom_range(0, 1) == 0) ? 'h20 : 'h102;
    endcase
  endfunction

  initial begin
    bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.wen = 1'b0;
    bus.raddr = '0; bus.ren = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      m_pri[k] = 0; m_vec[k] = '0; m_gw[k] = 0; m_extra[k] = 0;
    end
    m_en = '0; m_trig = '0; m_prev = '0; m_thresh = 0; m_valid = 0; m_id = 0; m_mvec = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset clears an active interrupt and all registers.
    wr('h0, 32'hFF);
    wr('h108, 32'd3);
    irq_sources = 8'h04;
    run(3);
    check("t1_pre_id", 32'(irq_id), 32'd3);
    do_reset();
    check("t1_valid", 32'(irq_valid), 32'd0);
    check("t1_id", 32'(irq_id), 32'd0);
    peek('h0, 32'd0, "t1_en");
    peek('h108, 32'd0, "t1_pri2");
    peek('h8, 32'd0, "t1_pending");
    irq_sources = '0;
    run(1);

    // Level source: latency, claim, re-pend on complete while line high.
    do_reset();
    wr('h0, 32'h1);
    wr('h100, 32'h1);
    wr('hC, 32'h0);
    irq_sources = 8'h01;
    cycle();
    check("t2_n1_valid", 32'(irq_valid), 32'd0);
    cycle();
    check("t2_valid", 32'(irq_valid), 32'd1);
    check("t2_id", 32'(irq_id), 32'd1);
    claim(32'd1, "t2_claim");
    cycle();
    check("t2_drop", 32'(irq_valid), 32'd0);
    wr('h10, 32'd1);
    cycle();
    check("t2_repend", 32'(irq_valid), 32'd1);
    irq_sources = '0;

    // Priority and tie-break, then threshold masking.
    do_reset();
    wr('h0, 32'hFF);
    wr('h104, 32'd2);
    wr('h10C, 32'd5);
    wr('h114, 32'd5);
    irq_sources = 8'h2A;
    run(2);
    check("t3_tie_id", 32'(irq_id), 32'd4);
    wr('hC, 32'd5);
    run(1);
    check("t3_thresh_valid", 32'(irq_valid), 32'd0);
    irq_sources = '0;

    // Edge source: two pulses while in service yield exactly one more claim.
    do_reset();
    wr('h0, 32'hFF);
    wr('h4, 32'h04);
    wr('h108, 32'd1);
    irq_sources = 8'h04;
    cycle();
    irq_sources = 8'h00;
    cycle();
    check("t4_id", 32'(irq_id), 32'd3);
    claim(32'd3, "t4_claim1");
    irq_sources = 8'h04; cycle();
    irq_sources = 8'h00; cycle();
    irq_sources = 8'h04; cycle();
    irq_sources = 8'h00; cycle();
    check("t4_serv_valid", 32'(irq_valid), 32'd0);
    wr('h10, 32'd3);
    cycle();
    check("t4_again_id", 32'(irq_id), 32'd3);
    claim(32'd3, "t4_claim2");
    wr('h10, 32'd3);
    run(3);
    check("t4_done_valid", 32'(irq_valid), 32'd0);

    // Stale claim after the winner is disabled.
    do_reset();
    wr('h0, 32'h1);
    wr('h100, 32'h1);
    irq_sources = 8'h01;
    run(2);
    wr('h0, 32'h0);
    check("t5_stale_id", 32'(irq_id), 32'd1);
    claim(32'd0, "t5_claim");
    peek('h8, 32'h1, "t5_pending");
    run(1);
    irq_sources = '0;

    // Byte strobes: upper-byte write leaves EN alone.
    wr('h0, 32'hFFFF_FFFF, 4'b0010);
    peek('h0, 32'd0, "strb_en");
    run(1);

`ifdef PLIC_V2_VECTOR_EN
    do_reset();
    wr('h0, 32'hFF);
    wr('h110, 32'd7);
    wr('h210, 32'h8000_0100);
    irq_sources = 8'h10;
    run(2);
    check("t6_id", 32'(irq_id), 32'd5);
    check("t6_mvec", mvec, 32'h8000_0100);
    irq_sources = '0;
`endif

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    wr('h0, 32'hFF);
    repeat (800) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) irq_sources[$urandom_range(0, NUM_SRC - 1)] ^= 1'b1;
      bus.wen   = 1'b0;
      bus.ren   = 1'b0;
      bus.raddr = ADDR_W'(pick_addr());
      case (op)
        0, 1: begin
          bus.waddr = ADDR_W'(pick_addr());
          bus.wdata = $urandom;
          bus.wstrb = 4'($urandom_range(0, 15));
          bus.wen   = 1'b1;
        end
        2: begin
          bus.waddr = 12'h010;
          bus.wdata = 32'($urandom_range(0, 10));
          bus.wstrb = 4'hF;
          bus.wen   = 1'b1;
        end
        3, 4: begin
          bus.raddr = 12'h010;
          bus.ren   = 1'b1;
        end
        default: ;
      endcase
      cycle();
    end
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
